// File: rtl/gate_tt_sequencer.sv
// Sweeps a 2-input gate through 00,01,10,11, samples it after SETTLE_CYCLES and flags truth-table mismatches.
// Latency: done 4*(SETTLE_CYCLES+1) cycles after start; no backpressure (start ignored while busy, abort always wins).
module gate_tt_sequencer #(
    parameter logic [3:0]  EXPECT_TT     = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    // SETTLE_CYCLES is legal in 1..15, so the reload value always fits 4 bits.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic [2:0] err_count_q, err_count_d;
    logic       mismatch;

    assign mismatch = (gate_x != EXPECT_TT[idx_q]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;

        if (abort) begin
            state_d     = S_IDLE;
            idx_d       = 2'd0;
            cnt_d       = 4'd0;
            fail_mask_d = 4'd0;
            err_count_d = 3'd0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_WAIT;
                        idx_d       = 2'd0;
                        cnt_d       = CNT_LOAD;
                        fail_mask_d = 4'd0;
                        err_count_d = 3'd0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        fail_mask_d[idx_q] = 1'b1;
                        err_count_d        = err_count_q + 3'd1;
                    end
                    // The last vector stays on the gate inputs while results are held.
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = CNT_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            fail_mask_q <= 4'd0;
            err_count_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign gate_a    = idx_q[1];
    assign gate_b    = idx_q[0];
    assign busy      = (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (fail_mask_q == 4'd0);
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed + randomized bench: two sequencers (settle 2 and settle 1) each driving a gate model whose truth table the bench chooses.
module tb_gate_tt_sequencer;

    localparam logic [3:0] EXP = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dut_tt = EXP;

    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       ga0, gb0, gx0, busy0, done0, pass0;
    logic [3:0] mask0;
    logic [2:0] errc0;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic       ga1, gb1, gx1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [2:0] errc1;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    // Gate under test: output for vector {a,b} is bit {a,b} of dut_tt.
    assign gx0 = dut_tt[{ga0, gb0}];
    assign gx1 = dut_tt[{ga1, gb1}];

    gate_tt_sequencer #(.EXPECT_TT(EXP), .SETTLE_CYCLES(2)) u_seq2 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .gate_a(ga0), .gate_b(gb0), .gate_x(gx0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(mask0), .err_count(errc0)
    );

    gate_tt_sequencer #(.EXPECT_TT(EXP), .SETTLE_CYCLES(1)) u_seq1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .gate_a(ga1), .gate_b(gb1), .gate_x(gx1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .err_count(errc1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected summary for a truth table: {gate_a,gate_b,busy,done,pass,fail_mask,err_count}
    function automatic logic [11:0] exp_done(input logic [3:0] tt);
        logic [3:0] m;
        m = tt ^ EXP;
        return {2'b11, 1'b0, 1'b1, (m == 4'd0), m, 3'($countones(m))};
    endfunction

    // One full sweep on the settle-2 sequencer; restart_at re-pulses start mid-sweep.
    task automatic run_sweep(input logic [3:0] tt, input int restart_at, input string tag);
        dut_tt = tt;
        start0 = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            chk({tag, "_vec"}, {busy0, done0, ga0, gb0}, {1'b1, 1'b0, 2'(k / 3)});
            start0 = (k == restart_at);
            step();
        end
        start0 = 1'b0;
        chk({tag, "_done"}, {ga0, gb0, busy0, done0, pass0, mask0, errc0}, exp_done(tt));
        step();
        step();
        chk({tag, "_hold"}, {ga0, gb0, busy0, done0, pass0, mask0, errc0}, exp_done(tt));
    endtask

    initial begin
        logic [3:0] tt;

        // Reset state
        #2;
        chk("reset0", {ga0, gb0, busy0, done0, pass0, mask0, errc0}, 12'd0);
        chk("reset1", {ga1, gb1, busy1, done1, pass1, mask1, errc1}, 12'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle0", {ga0, gb0, busy0, done0, pass0, mask0, errc0}, 12'd0);

        // Known gates against AND expectation
        run_sweep(4'b1000, -1, "and");
        run_sweep(4'b1110, -1, "or");
        run_sweep(4'b1111, -1, "stuck1");
        run_sweep(4'b0000, -1, "stuck0");

        // start re-pulsed while busy must be ignored
        run_sweep(4'b1000, 4, "restart_busy");

        // Randomized truth tables
        for (int r = 0; r < 6; r++) begin
            tt = 4'($urandom_range(0, 15));
            run_sweep(tt, int'($urandom_range(0, 20)), "rand");
        end

        // abort at E+5 -> IDLE with cleared results at E+6
        dut_tt = 4'b0000;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) step();
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("abort_idle", {ga0, gb0, busy0, done0, pass0, mask0, errc0}, 12'd0);
        for (int k = 0; k < 15; k++) step();
        chk("abort_nodone", {busy0, done0, mask0}, 6'd0);

        // abort beats start in the same cycle
        start0 = 1'b1;
        abort0 = 1'b1;
        step();
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("abort_prio", {ga0, gb0, busy0, done0}, 4'd0);

        // Asynchronous reset between edges mid-sweep
        dut_tt = 4'b0110;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < 7; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {ga0, gb0, busy0, done0, pass0, mask0, errc0}, 12'd0);
        rst_n = 1'b1;
        run_sweep(4'b0110, -1, "post_rst");

        // start held high on settle-1 sequencer: done every 9 cycles, results re-cleared
        start1 = 1'b1;
        dut_tt = 4'($urandom_range(0, 15));
        step();
        for (int k = 1; k <= 27; k++) begin
            step();
            chk("held_done", {31'd0, done1}, {31'd0, (k % 9 == 8)});
            if (k % 9 == 8) begin
                chk("held_res", {ga1, gb1, busy1, done1, pass1, mask1, errc1}, exp_done(dut_tt));
            end
            if (k % 9 == 0) begin
                chk("held_clr", {busy1, mask1, errc1}, {1'b1, 7'd0});
                dut_tt = 4'($urandom_range(0, 15));
            end
        end
        start1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
